wasm_run_ctrl: RTL

Run controller that sequences one WASM_TOP core through load → run → report. It streams a program image byte-wise into the core's instruction BRAM write port while holding the core in reset, then releases the core. It counts execution cycles and stops the run on finish, error or timeout, latching a status code for the host. It replaces the testbench-only $readmemh preload and clk_cnt logic with synthesizable control.

---
 rtl/wasm_run_ctrl.sv | 139 +++++++++++++
 1 files changed

// File: rtl/wasm_run_ctrl.sv
// Run controller for one WASM core: streams a program image into the instruction
// BRAM with the core held in reset, then runs it and latches a termination status.
module wasm_run_ctrl #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_load_start,
    input  logic              i_load_valid,
    output logic              o_load_ready,
    input  logic [DATA_W-1:0] i_load_data,
    input  logic              i_load_last,
    input  logic              i_start,
    input  logic              i_clear,
    input  logic [CNT_W-1:0]  i_timeout,
    output logic              o_bram_we,
    output logic [ADDR_W-1:0] o_bram_addr,
    output logic [DATA_W-1:0] o_bram_wdata,
    output logic              o_core_rst_n,
    input  logic              i_instr_finish,
    input  logic              i_instr_error,
    input  logic              i_stack_exceed,
    input  logic              i_stack_empty_pop,
    output logic              o_busy,
    output logic              o_done,
    output logic [2:0]        o_status,
    output logic [CNT_W-1:0]  o_cycle_cnt
);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    localparam logic [2:0] ST_FINISH   = 3'd1;
    localparam logic [2:0] ST_ERROR    = 3'd2;
    localparam logic [2:0] ST_EXCEED   = 3'd3;
    localparam logic [2:0] ST_EMPTY    = 3'd4;
    localparam logic [2:0] ST_TIMEOUT  = 3'd5;
    localparam logic [2:0] ST_OVERFLOW = 3'd6;

    state_t            state;
    logic [ADDR_W-1:0] wr_addr;
    logic [2:0]        term_code;
    logic              accept;

    assign accept = i_load_valid && o_load_ready;

    // Termination priority; a zero code means the run continues this cycle.
    always_comb begin
        term_code = 3'd0;
        if (i_instr_error)
            term_code = ST_ERROR;
        else if (i_stack_exceed)
            term_code = ST_EXCEED;
        else if (i_stack_empty_pop)
            term_code = ST_EMPTY;
        else if (i_instr_finish)
            term_code = ST_FINISH;
        else if ((i_timeout != '0) && (o_cycle_cnt == i_timeout))
            term_code = ST_TIMEOUT;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= IDLE;
            wr_addr      <= '0;
            o_load_ready <= 1'b0;
            o_bram_we    <= 1'b0;
            o_bram_addr  <= '0;
            o_bram_wdata <= '0;
            o_core_rst_n <= 1'b0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_status     <= 3'd0;
            o_cycle_cnt  <= '0;
        end else begin
            o_bram_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_load_start) begin
                        state        <= LOAD;
                        wr_addr      <= '0;
                        o_load_ready <= 1'b1;
                        o_busy       <= 1'b1;
                    end else if (i_start) begin
                        state        <= RUN;
                        o_core_rst_n <= 1'b1;
                        o_cycle_cnt  <= '0;
                        o_status     <= 3'd0;
                        o_busy       <= 1'b1;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        o_bram_we    <= 1'b1;
                        o_bram_addr  <= wr_addr;
                        o_bram_wdata <= i_load_data;
                        if (wr_addr != ADDR_MAX)
                            wr_addr <= wr_addr + 1'b1;
                        if (i_load_last) begin
                            state        <= IDLE;
                            o_load_ready <= 1'b0;
                            o_busy       <= 1'b0;
                        end else if (wr_addr == ADDR_MAX) begin
                            // Image larger than the BRAM: keep the last byte, refuse the rest.
                            state        <= DONE;
                            o_status     <= ST_OVERFLOW;
                            o_load_ready <= 1'b0;
                            o_busy       <= 1'b0;
                            o_done       <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (term_code != 3'd0) begin
                        state        <= DONE;
                        o_status     <= term_code;
                        o_core_rst_n <= 1'b0;
                        o_busy       <= 1'b0;
                        o_done       <= 1'b1;
                    end else if (o_cycle_cnt != CNT_MAX) begin
                        o_cycle_cnt <= o_cycle_cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (i_clear) begin
                        state  <= IDLE;
                        o_done <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
